// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional leading-zero suppression is compiled in with `define SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl #(
   parameter int DIGIT_CYC = 100000,
   parameter int BLANK_CYC = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_in,
   input  logic [3:0]  en_mask,
   input  logic        load,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [3:0]  an,
   output logic        frame_tick
);

   localparam int CW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYC - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

   localparam logic [0:0] ST_BLANK = 1'b0;
   localparam logic [0:0] ST_DRIVE = 1'b1;

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [1:0]    idx;
   logic [0:0]    state;
   logic [0:0]    state_next;
   logic          wrapped;
   logic          slot_end;
   logic          boundary;

   logic [15:0]   act_digits;
   logic [3:0]    act_dp;
   logic [3:0]    act_en;
   logic [15:0]   pend_digits;
   logic [3:0]    pend_dp;
   logic [3:0]    pend_en;
   logic          pend_valid;

   logic [3:0]    show_en;
   logic [3:0]    cur_val;
   logic          lit;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'h0:    decode = 7'b0111111;
         4'h1:    decode = 7'b0000110;
         4'h2:    decode = 7'b1011011;
         4'h3:    decode = 7'b1001111;
         4'h4:    decode = 7'b1100110;
         4'h5:    decode = 7'b1101101;
         4'h6:    decode = 7'b1111101;
         4'h7:    decode = 7'b0000111;
         4'h8:    decode = 7'b1111111;
         4'h9:    decode = 7'b1101111;
         4'hA:    decode = 7'b1110111;
         4'hB:    decode = 7'b1111100;
         4'hC:    decode = 7'b0111001;
         4'hD:    decode = 7'b1011110;
         4'hE:    decode = 7'b1111001;
         default: decode = 7'b1110001;
      endcase
   endfunction

   assign slot_end   = (cnt == CNT_LAST);
   assign boundary   = slot_end && (idx == 2'd3);
   assign cnt_next   = slot_end ? '0 : cnt + 1'b1;
   assign state_next = (cnt_next < CNT_BLANK) ? ST_BLANK : ST_DRIVE;

   // wrapped marks the first internal cycle of a frame that followed a real 3->0 wrap,
   // so the very first frame after reset produces no frame_tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= 2'd0;
         state   <= ST_BLANK;
         wrapped <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         state   <= state_next;
         wrapped <= boundary;
         if (slot_end) begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Active values only change on the frame boundary; a load in that very cycle bypasses pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         act_digits  <= '0;
         act_dp      <= '0;
         act_en      <= '0;
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_en     <= '0;
         pend_valid  <= 1'b0;
      end else if (load && boundary) begin
         act_digits <= digits;
         act_dp     <= dp_in;
         act_en     <= en_mask;
         pend_valid <= 1'b0;
      end else begin
         if (boundary && pend_valid) begin
            act_digits <= pend_digits;
            act_dp     <= pend_dp;
            act_en     <= pend_en;
            pend_valid <= 1'b0;
         end
         if (load) begin
            pend_digits <= digits;
            pend_dp     <= dp_in;
            pend_en     <= en_mask;
            pend_valid  <= 1'b1;
         end
      end
   end

`ifdef SEG_SCAN_LZ_BLANK_EN
   logic above_off;

   // Walk down from the top digit; a zero without dp is hidden only while everything above is dark.
   always_comb begin
      show_en   = act_en;
      above_off = 1'b1;
      for (int k = 3; k >= 1; k--) begin
         if (above_off && (act_digits[4*k +: 4] == 4'd0) && !act_dp[k]) begin
            show_en[k] = 1'b0;
         end
         above_off = !show_en[k];
      end
   end
`else
   assign show_en = act_en;
`endif

   assign cur_val = act_digits[{idx, 2'b00} +: 4];
   assign lit     = (state == ST_DRIVE) && show_en[idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         an         <= 4'b1111;
         seg        <= 7'b1111111;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         an         <= lit ? ~(4'b0001 << idx) : 4'b1111;
         seg        <= lit ? ~decode(cur_val) : 7'b1111111;
         dp         <= lit ? ~act_dp[idx] : 1'b1;
         frame_tick <= wrapped;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl with DIGIT_CYC=8, BLANK_CYC=2.
// Expected lit digits follow SEG_SCAN_LZ_BLANK_EN when it is defined for the build.
module tb_seg_scan_ctrl;

   localparam int DIGIT_CYC = 8;
   localparam int BLANK_CYC = 2;
   localparam int FRAME_CYC = 4 * DIGIT_CYC;
`ifdef SEG_SCAN_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   typedef struct {
      logic [15:0]     digits;
      logic [3:0]      dp_in;
      logic [3:0]      en_mask;
      logic [3:0][6:0] seg_exp;
      logic [3:0]      lit_exp;
      logic [3:0]      dp_exp;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic [3:0]  en_mask;
   logic        load;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        frame_tick;

   int tests;
   int failures;

   vec_t vecs [7];
   vec_t dark;
   vec_t v_aaaa;
   vec_t v_5555;
   vec_t prev;

   seg_scan_ctrl #(
      .DIGIT_CYC(DIGIT_CYC),
      .BLANK_CYC(BLANK_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .digits(digits),
      .dp_in(dp_in),
      .en_mask(en_mask),
      .load(load),
      .seg(seg),
      .dp(dp),
      .an(an),
      .frame_tick(frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input vec_t v);
      digits  = v.digits;
      dp_in   = v.dp_in;
      en_mask = v.en_mask;
      load    = 1'b1;
   endtask

   // t is the pin cycle within a frame; t=0 is the frame_tick cycle.
   task automatic checkOutput(input vec_t e, input int t);
      int         slot;
      bit         lit_now;
      logic [3:0] exp_an;
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic       exp_ft;
      slot    = t / DIGIT_CYC;
      lit_now = ((t % DIGIT_CYC) >= BLANK_CYC) && e.lit_exp[slot];
      exp_an  = lit_now ? ~(4'b0001 << slot) : 4'b1111;
      exp_seg = lit_now ? e.seg_exp[slot] : 7'b1111111;
      exp_dp  = lit_now ? e.dp_exp[slot] : 1'b1;
      exp_ft  = (t == 0);
      tests++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp || frame_tick !== exp_ft) begin
         failures++;
         $display("[TB] FAIL frame_cycle t=%0d: an=%b seg=%b dp=%b ft=%b, want an=%b seg=%b dp=%b ft=%b",
                  t, an, seg, dp, frame_tick, exp_an, exp_seg, exp_dp, exp_ft);
      end
   endtask

   task automatic checkFrame(input vec_t e);
      checkOutput(e, 0);
      for (int t = 1; t < FRAME_CYC; t++) begin
         @(negedge clk);
         load = 1'b0;
         checkOutput(e, t);
      end
   endtask

   task automatic waitFrameTick();
      int n;
      n = 0;
      while (frame_tick !== 1'b1 && n < 2 * FRAME_CYC) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (frame_tick !== 1'b1) begin
         failures++;
         $display("[TB] FAIL frame_tick_wait: frame_tick=%b after %0d cycles, want 1", frame_tick, n);
      end
   endtask

   // Reset, then 40 dark cycles; k counts rising edges after release, first tick follows the wrap at k=32.
   task automatic resetAndCheckDark();
      rst  = 1'b1;
      load = 1'b0;
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_tick !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_values: an=%b seg=%b dp=%b ft=%b, want an=1111 seg=1111111 dp=1 ft=0",
                  an, seg, dp, frame_tick);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         tests++;
         if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1 || frame_tick !== (k == FRAME_CYC + 1)) begin
            failures++;
            $display("[TB] FAIL dark_after_reset k=%0d: an=%b seg=%b dp=%b ft=%b, want an=1111 seg=1111111 dp=1 ft=%b",
                     k, an, seg, dp, frame_tick, (k == FRAME_CYC + 1));
         end
      end
   endtask

   initial begin
      tests    = 0;
      failures = 0;
      rst      = 1'b1;
      load     = 1'b0;
      digits   = '0;
      dp_in    = '0;
      en_mask  = '0;

      // {digits, dp_in, en_mask, active-low seg {d3,d2,d1,d0}, lit digits, active-low dp}
      vecs[0] = '{16'h1234, 4'b0000, 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111, 4'b1111};
      vecs[1] = '{16'h89EF, 4'b0101, 4'b1111, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b1111, 4'b1010};
      vecs[2] = '{16'h6BCD, 4'b1111, 4'b1010, {7'h02, 7'h03, 7'h46, 7'h21}, 4'b1010, 4'b0000};
      vecs[3] = '{16'h0070, 4'b0000, 4'b1111, {7'h40, 7'h40, 7'h78, 7'h40},
                  LZ ? 4'b0011 : 4'b1111, 4'b1111};
      vecs[4] = '{16'h0005, 4'b0100, 4'b1111, {7'h40, 7'h40, 7'h40, 7'h12},
                  LZ ? 4'b0111 : 4'b1111, 4'b1011};
      vecs[5] = '{16'h1005, 4'b0000, 4'b0111, {7'h79, 7'h40, 7'h40, 7'h12},
                  LZ ? 4'b0001 : 4'b0111, 4'b1111};
      vecs[6] = '{16'h0000, 4'b0000, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000, 4'b1111};
      dark    = '{16'h0000, 4'b0000, 4'b0000, {4{7'h7f}}, 4'b0000, 4'b1111};
      v_aaaa  = '{16'hAAAA, 4'b0000, 4'b1111, {4{7'h08}}, 4'b1111, 4'b1111};
      v_5555  = '{16'h5555, 4'b0000, 4'b1111, {4{7'h12}}, 4'b1111, 4'b1111};

      resetAndCheckDark();
      waitFrameTick();

      // Each load lands mid-frame: the current frame keeps the previous values, the next shows the new ones.
      prev = dark;
      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
         checkFrame(prev);
         @(negedge clk);
         prev = vecs[i];
      end

      // Two loads in one frame: only the later one is ever displayed.
      applyStimulus(v_aaaa);
      checkOutput(prev, 0);
      for (int t = 1; t < FRAME_CYC; t++) begin
         @(negedge clk);
         load = 1'b0;
         if (t == 4) applyStimulus(v_5555);
         checkOutput(prev, t);
      end
      @(negedge clk);

      // Pending load at t=4, then a load in the boundary cycle bypasses it and clears pend_valid.
      checkOutput(v_5555, 0);
      for (int t = 1; t < FRAME_CYC; t++) begin
         @(negedge clk);
         load = 1'b0;
         if (t == 4) applyStimulus(vecs[0]);
         if (t == FRAME_CYC - 2) applyStimulus(vecs[1]);
         checkOutput(v_5555, t);
      end
      @(negedge clk);
      checkFrame(vecs[1]);
      @(negedge clk);
      checkFrame(vecs[1]);
      @(negedge clk);

      // Reset in the middle of a lit slot with a load still pending.
      applyStimulus(vecs[0]);
      for (int t = 1; t <= 12; t++) begin
         @(negedge clk);
         load = 1'b0;
      end
      resetAndCheckDark();

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for the board's 4-digit common-anode 7-segment display. The four digits share one active-low segment bus (`seg`, `dp`), so the block cycles through the digits one at a time. For each digit it drives that digit's active-low anode enable and the matching segment pattern, with a blanking gap between digits to suppress ghosting. It sits between the value-producing logic and the `seg`/`dp`/`an` pins, and replaces any static single-digit decode on those pins.

## Interface
- `DIGIT_CYC`, default 100000: clock cycles per digit slot (1 ms at 100 MHz).
- `BLANK_CYC`, default 1000: cycles at the start of each slot with all anodes off. Legal range is 1 ≤ BLANK_CYC < DIGIT_CYC.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset. One clock domain; reset is synchronous and active-high.
- `digits`, input, 16: four 4-bit values, digit n = `digits[4n+3:4n]`, digit 0 rightmost.
- `dp_in`, input, 4: decimal point request per digit, 1 = on.
- `en_mask`, input, 4: per-digit enable, 1 = digit may light.
- `load`, input, 1: one-cycle strobe that captures `digits`, `dp_in` and `en_mask` into the pending buffer.
- `seg`, output, 7: segments a..g on bits 0..6, active low.
- `dp`, output, 1: decimal point, active low.
- `an`, output, 4: digit anode enables, active low.
- `frame_tick`, output, 1: one-cycle pulse at the start of each frame.

## Operation
- Two registered states per slot: BLANK while `cnt < BLANK_CYC`, DRIVE while `BLANK_CYC ≤ cnt ≤ DIGIT_CYC-1`.
- `cnt` wraps from DIGIT_CYC-1 to 0. On that wrap, `idx` advances 0→1→2→3→0.
- BLANK: `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1.
- DRIVE: `an` is low on bit `idx` only. `seg` is the decode of the active value for digit `idx`. `dp` = ~active dp for that digit.
- If `en_mask[idx]` = 0, DRIVE behaves exactly like BLANK.
- Decode, active-high patterns before inversion: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Double buffering:
  - `load` writes the pending buffer and sets `pend_valid`.
  - At each frame boundary (idx 3→0 wrap), if `pend_valid`, pending is copied to active and `pend_valid` clears.
  - If `load` is high in the boundary cycle itself, the inputs bypass pending and go straight to active, and `pend_valid` clears.
  - Multiple loads within one frame: the last one wins.
- Displayed values therefore never change mid-frame.

## Timing
- All outputs are registered. Pins reflect the internal state (`cnt`, `idx`) of the previous cycle, so latency is 1 cycle.
- Slot n, frame-relative cycles s = n·DIGIT_CYC: anodes stay off for s+1 … s+BLANK_CYC and digit n is lit for s+BLANK_CYC+1 … s+DIGIT_CYC.
- Frame period is 4·DIGIT_CYC cycles.
- `frame_tick` is high for the single cycle where the pins begin slot 0's blank. This is also the first cycle the newly promoted active values can appear (they show once slot 0 enters DRIVE).
- Reset values:
  - `an` = 4'b1111, `seg` = 7'b1111111, `dp` = 1, `frame_tick` = 0.
  - `cnt` = 0, `idx` = 0.
  - Active and pending buffers all zero; `en_mask` active = 4'b0000, so the display is dark until the first load is promoted.
  - `pend_valid` = 0.
- `rst` asserted mid-slot: on the next edge, all outputs and state return to reset values; a pending load is discarded.
- Note: the first frame after reset begins at `cnt` = 0 but does not assert `frame_tick`. The first `frame_tick` occurs at the first 3→0 wrap.

## Configuration
- `SEG_SCAN_LZ_BLANK_EN`
- Defined: leading-zero suppression.
  - Digit k (k = 3, 2, 1) is treated as disabled when its active value is 0, its dp is off, and every digit above k is likewise suppressed or disabled.
  - Digit 0 is never suppressed.
  - Evaluated on the active buffer only.
- Undefined: every digit with `en_mask` = 1 is shown, including leading zeros.

## Test plan
Parameters for all scenarios: DIGIT_CYC=8, BLANK_CYC=2.
- Reset, then run 40 cycles with no load: `an` = 1111 and `seg` = 1111111 throughout; `frame_tick` pulses at cycle 32 relative to reset release.
- Load `digits`=16'h1234, `en_mask`=1111, `dp_in`=0000 at cycle 5: no change until the frame boundary.
  - Next frame, slot 0: `an`=1110, `seg`=~1100110 ("4").
  - Slot 3: `an`=0111, `seg`=~0000110 ("1").
- Check every slot: `an`=1111 for exactly 2 cycles, then one-hot-low for 6 cycles.
- Load 16'hAAAA mid-frame, then 16'h5555 four cycles later: the next frame shows "5555" only; "AAAA" never appears.
- Load coincident with the boundary cycle: the values appear in that same frame; `pend_valid` ends at 0.
- `digits`=16'h0070, `dp_in`=0000, `en_mask`=1111:
  - With the macro: digits 3 and 2 stay dark; digit 1 shows "7"; digit 0 shows "0".
  - Without the macro: all four digits light.
